// File: rtl/dmem_bram_responder_if.sv
// BRAM-style port between the load/store front-end (master) and the data memory (slave).
`timescale 1ns/1ps
interface dmem_bram_responder_if #(
  parameter int unsigned W = 32
) ();
  logic [W/8-1:0] wea;
  logic [W-1:0]   dina;
  logic [31:0]    bram_addr;
  logic [W-1:0]   bram_read;
  logic           ready;
  logic           addr_fault;

  modport master (
    output wea, dina, bram_addr,
    input  bram_read, ready, addr_fault
  );

  modport slave (
    input  wea, dina, bram_addr,
    output bram_read, ready, addr_fault
  );
endinterface

// File: rtl/dmem_bram_responder.sv
// Word-addressed byte-lane-writable data memory with one-cycle write-first reads,
// a post-reset clear sweep, and out-of-range address flagging.
`timescale 1ns/1ps
module dmem_bram_responder #(
  parameter int unsigned DEPTH_LOG2 = 10,
  parameter int unsigned W          = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  dmem_bram_responder_if.slave   bus
);
  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
  localparam int unsigned LANES = W / 8;
  localparam int unsigned AW    = 32;

  typedef enum logic {S_CLEAR, S_READY} state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [DEPTH_LOG2-1:0] r_clr_cnt;
  logic [DEPTH_LOG2-1:0] w_clr_cnt_nxt;
  logic [W-1:0]          r_mem [DEPTH];
  logic [W-1:0]          r_bram_read;
  logic [W-1:0]          w_bram_read_nxt;
  logic                  r_ready;
  logic                  r_addr_fault;
  logic                  w_addr_fault_nxt;

  logic                  w_mem_we;
  logic [DEPTH_LOG2-1:0] w_mem_idx;
  logic [W-1:0]          w_mem_wdata;

  logic [DEPTH_LOG2-1:0] w_idx;
  logic                  w_in_range;
  logic [W-1:0]          w_old;
  logic [W-1:0]          w_merged;

  assign w_idx      = bus.bram_addr[DEPTH_LOG2-1:0];
  assign w_in_range = (bus.bram_addr[AW-1:DEPTH_LOG2] == '0);
  assign w_old      = r_mem[w_idx];

  // Write-first merge: enabled lanes take new data, the rest keep the stored word.
  always_comb begin
    w_merged = w_old;
    for (int i = 0; i < LANES; i++) begin
      if (bus.wea[i]) w_merged[8*i +: 8] = bus.dina[8*i +: 8];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_CLEAR;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_CLEAR: if (r_clr_cnt == DEPTH_LOG2'(DEPTH - 1)) w_state_nxt = S_READY;
      S_READY: w_state_nxt = S_READY;
      default: w_state_nxt = S_CLEAR;
    endcase
  end

  always_comb begin
    w_clr_cnt_nxt    = r_clr_cnt;
    w_mem_we         = 1'b0;
    w_mem_idx        = w_idx;
    w_mem_wdata      = w_merged;
    w_bram_read_nxt  = '0;
    w_addr_fault_nxt = 1'b0;
    case (r_state)
      S_CLEAR: begin
        w_mem_we      = 1'b1;
        w_mem_idx     = r_clr_cnt;
        w_mem_wdata   = '0;
        w_clr_cnt_nxt = r_clr_cnt + DEPTH_LOG2'(1);
      end
      S_READY: begin
        if (w_in_range) begin
          w_mem_we        = |bus.wea;
          w_bram_read_nxt = w_merged;
        end else begin
          w_addr_fault_nxt = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_clr_cnt    <= '0;
      r_bram_read  <= '0;
      r_ready      <= 1'b0;
      r_addr_fault <= 1'b0;
    end else begin
      r_clr_cnt    <= w_clr_cnt_nxt;
      r_bram_read  <= w_bram_read_nxt;
      r_ready      <= r_ready | (w_state_nxt == S_READY);
      r_addr_fault <= w_addr_fault_nxt;
    end
  end

  // Array has no reset; the sweep zeroes it after every reset release.
  always_ff @(posedge clk) begin
    if (w_mem_we) r_mem[w_mem_idx] <= w_mem_wdata;
  end

  assign bus.bram_read  = r_bram_read;
  assign bus.ready      = r_ready;
  assign bus.addr_fault = r_addr_fault;
endmodule

// File: tb/tb_dmem_bram_responder.sv
// Scoreboard bench for dmem_bram_responder: sweep timing, merges, faults, reset behaviour.
`timescale 1ns/1ps
module tb_dmem_bram_responder;
  typedef struct {
    string       tag;
    logic [31:0] data;
    logic        fault;
  } exp_t;

  logic clk;
  logic rst;
  logic tb_valid;
  int   n_checks;
  int   n_err;
  exp_t sb[$];
  logic [31:0] mdl [16];

  dmem_bram_responder_if #(.W(32)) bus ();

  dmem_bram_responder #(.DEPTH_LOG2(10), .W(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Response monitor: every access sampled on an edge is answered right after it.
  always begin : mon
    logic v;
    exp_t e;
    @(posedge clk);
    v = tb_valid;
    #1;
    if (v) begin
      if (sb.size() == 0) begin
        check("sb_empty", 32'd0, 32'd1);
      end else begin
        e = sb.pop_front();
        check(e.tag, bus.bram_read, e.data);
        check({e.tag, "_flt"}, 32'(bus.addr_fault), 32'(e.fault));
      end
    end
  end

  task automatic access(input string tag, input logic [31:0] addr, input logic [3:0] we,
                        input logic [31:0] d, input logic [31:0] exp_d, input logic exp_f);
    exp_t e;
    @(negedge clk);
    bus.bram_addr = addr;
    bus.wea       = we;
    bus.dina      = d;
    tb_valid      = 1'b1;
    e.tag = tag; e.data = exp_d; e.fault = exp_f;
    sb.push_back(e);
  endtask

  task automatic idle_drain();
    @(negedge clk);
    tb_valid = 1'b0;
    bus.wea  = 4'b0000;
    for (int k = 0; k < 20 && sb.size() != 0; k++) @(posedge clk);
    #2;
    check("drain", 32'(sb.size()), 32'd0);
  endtask

  // Count edges until ready; optionally attempt a write to word 7 on sweep edge 3.
  task automatic sweep(input bit poke);
    int first;
    first = 0;
    for (int e = 1; e <= 2000 && first == 0; e++) begin
      @(posedge clk);
      #1;
      if (bus.ready) first = e;
      if (poke && e == 2) begin
        bus.bram_addr = 32'd7;
        bus.wea       = 4'b1111;
        bus.dina      = 32'h12345678;
      end
      if (poke && e == 3) begin
        check("clr_read", bus.bram_read, 32'd0);
        check("clr_flt", 32'(bus.addr_fault), 32'd0);
        bus.wea  = 4'b0000;
        bus.dina = 32'd0;
      end
    end
    check("ready_edge", 32'(first), 32'd1024);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation timed out");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] mg;
    logic [3:0]  w;
    logic [31:0] d;
    int          ix;
    n_checks = 0;
    n_err    = 0;
    tb_valid = 1'b0;
    rst      = 1'b1;
    bus.wea       = 4'b0000;
    bus.dina      = 32'd0;
    bus.bram_addr = 32'd0;
    for (int i = 0; i < 16; i++) mdl[i] = 32'd0;

    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", 32'(bus.ready), 32'd0);
    check("rst_read", bus.bram_read, 32'd0);
    check("rst_flt", 32'(bus.addr_fault), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    sweep(1'b1);

    access("rd_w0", 32'd0, 4'b0000, 32'd0, 32'd0, 1'b0);
    access("rd_w1023", 32'd1023, 4'b0000, 32'd0, 32'd0, 1'b0);
    access("rd_w7", 32'd7, 4'b0000, 32'd0, 32'd0, 1'b0);
    access("wr_w5", 32'd5, 4'b1111, 32'hDEADBEEF, 32'hDEADBEEF, 1'b0);
    access("rd_w5", 32'd5, 4'b0000, 32'd0, 32'hDEADBEEF, 1'b0);
    access("byte2", 32'd5, 4'b0100, 32'h00AA0000, 32'hDEAABEEF, 1'b0);
    access("half0", 32'd5, 4'b0011, 32'h00001234, 32'hDEAA1234, 1'b0);
    access("oor_400", 32'h400, 4'b1111, 32'hFFFFFFFF, 32'd0, 1'b1);
    access("rd_w0_b", 32'd0, 4'b0000, 32'd0, 32'd0, 1'b0);
    access("oor_405", 32'h405, 4'b1111, 32'h11111111, 32'd0, 1'b1);
    access("oor_msb", 32'h80000005, 4'b0000, 32'd0, 32'd0, 1'b1);
    access("rd_w5_b", 32'd5, 4'b0000, 32'd0, 32'hDEAA1234, 1'b0);

    for (int n = 0; n < 40; n++) begin
      ix = int'($urandom_range(15));
      w  = 4'($urandom_range(15));
      d  = $urandom;
      mg = mdl[ix];
      for (int l = 0; l < 4; l++) if (w[l]) mg[8*l +: 8] = d[8*l +: 8];
      mdl[ix] = mg;
      access("rnd", 32'(16 + ix), w, d, mg, 1'b0);
    end

    access("wr_w9", 32'd9, 4'b1111, 32'hCAFEF00D, 32'hCAFEF00D, 1'b0);
    access("rd_w9", 32'd9, 4'b0000, 32'd0, 32'hCAFEF00D, 1'b0);
    idle_drain();

    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("mid_rst_ready", 32'(bus.ready), 32'd0);
    check("mid_rst_read", bus.bram_read, 32'd0);
    #4;
    rst = 1'b0;
    sweep(1'b0);
    access("rd_w9_post", 32'd9, 4'b0000, 32'd0, 32'd0, 1'b0);
    access("rd_w5_post", 32'd5, 4'b0000, 32'd0, 32'd0, 1'b0);
    idle_drain();

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule

// File: doc/dmem_bram_responder.md
# dmem_bram_responder

Word-addressed, byte-lane-writable data memory that answers the load/store front-end's BRAM port (`wea`, `dina`, `bram_addr` in; `bram_read` out). It replaces the external block-RAM IP in simulation and on targets without it. Read latency is one clock, write-first on collision. After every reset a sequential clear sweep zeroes the array before `ready` is asserted. Out-of-range word addresses are flagged rather than aliased.

## Interface
- `DEPTH_LOG2`, 10, log2 of number of 32-bit words (default 1024 words = 4 KiB).
- `W`, 32, data width; fixed at 32, four 8-bit lanes.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  reset, asynchronous, active-high.
- `wea`  in  4  byte-lane write enables; bit i writes `dina[8i+7:8i]`.
- `dina`  in  32  write data, already lane-positioned by the requester.
- `bram_addr`  in  32  word address (byte address >> 2).
- `bram_read`  out  32  registered read data for the address presented on the previous edge.
- `ready`  out  1  high once the clear sweep has completed; accesses are only honoured while high.
- `addr_fault`  out  1  registered pulse, aligned with `bram_read`, for an access whose `bram_addr[31:DEPTH_LOG2]` is non-zero.

## Operation
- State machine has two states, CLEAR and READY. A 2^DEPTH_LOG2 × 32 register array is indexed by `idx = bram_addr[DEPTH_LOG2-1:0]`; `in_range = (bram_addr[31:DEPTH_LOG2] == 0)`.
- Reset (async assert) forces state CLEAR, `clr_cnt` to 0, `bram_read` to 0, `ready` to 0, and `addr_fault` to 0. Array contents are not reset asynchronously; the sweep handles them.
- CLEAR, on each edge:
  - writes 0 to `mem[clr_cnt]` and increments `clr_cnt`.
  - When `clr_cnt == 2^DEPTH_LOG2-1` it writes the last word and moves to READY.
  - External `wea`/`dina`/`bram_addr` are ignored; `bram_read` is held at 0 and `addr_fault` at 0.
- READY, on each edge:
  - In range: for each lane i with `wea[i]`, `mem[idx]` lane i <= `dina` lane i. `bram_read` <= merged word, where written lanes take `dina` and other lanes take the old `mem[idx]` (write-first). `addr_fault` <= 0.
  - Out of range: no array write; `bram_read` <= 0; `addr_fault` <= 1.
  - `wea == 0` is a pure read.
- `ready` <= 1 on the edge that enters READY and stays 1 until reset.
- Reset asserted mid-sweep or mid-operation aborts immediately and the full sweep restarts after release; data written before the reset is lost.
- Misalignment is the requester's concern. This block never sees byte offsets and performs no sign extension.

## Timing
- Clear sweep takes exactly 2^DEPTH_LOG2 edges after reset release. `ready` is visible high after edge number 2^DEPTH_LOG2, counting the first post-release edge as 1.
- Read latency is 1 cycle: the address is sampled at edge N and data is valid on `bram_read` after edge N until edge N+1.
- Back-to-back accesses need no bubble. A write at edge N followed by a read of the same word at edge N+1 returns the new data.
- Same-cycle write and read of one word returns the post-write merged word.
- `addr_fault` has the same 1-cycle latency as `bram_read` and lasts one cycle per faulting access.
- There are no combinational paths from inputs to outputs.

## Test plan
- Reset, then run: `ready` stays 0 for 1023 edges and reads 1 after edge 1024. Reading word 0 and word 1023 then returns `0x00000000` with `addr_fault=0`.
- Write `wea=1111`, `dina=0xDEADBEEF` to word 5; the next-cycle `bram_read` is `0xDEADBEEF`. A pure read of word 5 on the following cycle also returns `0xDEADBEEF`.
- Byte/half merge on word 5 (holding `0xDEADBEEF`):
  - `wea=0100`, `dina=0x00AA0000` returns `0xDEAABEEF` on the same-access response.
  - Then `wea=0011`, `dina=0x00001234` gives `0xDEAA1234`.
- Out of range: `bram_addr=0x400`, `wea=1111`, `dina=0xFFFFFFFF` gives `bram_read=0` and `addr_fault=1` for one cycle. A subsequent read of word 0 returns `0x00000000`, proving no aliasing.
- Writes during CLEAR: drive `wea=1111`, `dina=0x12345678`, word 7 at sweep edge 3. After `ready`, reading word 7 returns 0.
- Reset mid-operation: write `0xCAFEF00D` to word 9, then assert `rst` for half a cycle. `ready` and `bram_read` drop to 0 immediately; after re-sweep, word 9 reads 0.
